// File: rtl/spi_slave_stream.sv
`timescale 1ns/1ps
// spi_slave_stream
//   SPI slave (all four CPOL/CPHA modes) bridging an MCU SPI link to
//   valid/ready word streams on the system clock. Multi-word bursts inside
//   one chip-select window, RX/TX FIFOs, sticky overrun/underrun flags.
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   spi_sclk/mosi/cs_n          asynchronous SPI pins (cs_n active low)
//   spi_miso                    registered serial out, 0 while idle
//   cpol, cpha                  SPI mode, captured at chip-select assertion
//   rx_data/rx_valid/rx_ready   RX FIFO head stream (pop on valid & ready)
//   tx_data/tx_valid/tx_ready   TX FIFO push stream (push on valid & ready)
//   rx_overrun, tx_underrun     sticky error flags, cleared by clear_flags
//   busy                        a transaction is in progress
module spi_slave_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    input  logic                  clear_flags,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_XFER} state_e;

    // ---------------- pin synchronizers ----------------
    // Stage [1] is the synchronized value, stage [2] the history flop.
    // cs_n resets to "asserted" so that a CS already held low when reset is
    // released produces no falling edge and cannot start a transaction.
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    logic cs_fall, cs_rise;
    assign cs_fall = ~cs_q[1] &  cs_q[2];
    assign cs_rise =  cs_q[1] & ~cs_q[2];

    // ---------------- engine state ----------------
    state_e                state_q;
    logic                  cpol_q, cpha_q;
    logic [BW-1:0]         bit_cnt_q;
    logic                  load_pend_q;
    logic                  from_fifo_q;
    logic                  miso_q;
    logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q;
    logic                  ovr_q, udr_q;

    // ---------------- FIFO state ----------------
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [AW:0]           rx_cnt_q, tx_cnt_q;

    // ---------------- edge classification ----------------
    logic s_now, s_prev, lead_e, trail_e, in_xfer, sample_e, shift_e;
    logic first_bit, word_done;
    assign s_now    = sclk_q[1] ^ cpol_q;
    assign s_prev   = sclk_q[2] ^ cpol_q;
    assign lead_e   =  s_now & ~s_prev;
    assign trail_e  = ~s_now &  s_prev;
    // CS deassert takes priority over any SCLK edge seen in the same cycle.
    assign in_xfer  = (state_q == ST_XFER) && !cs_rise;
    assign sample_e = in_xfer && (cpha_q ? trail_e : lead_e);
    assign shift_e  = in_xfer && (cpha_q ? lead_e : trail_e);
    assign first_bit = (bit_cnt_q == '0);
    assign word_done = sample_e && (bit_cnt_q == LAST_BIT);

    logic [DATA_WIDTH-1:0] rx_word, tx_head, load_word;
    logic rx_full, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic set_ovr, set_udr;

    assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_q[1]};
    assign rx_full   = (rx_cnt_q == DEPTH_C);
    assign tx_full   = (tx_cnt_q == DEPTH_C);
    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_head   = tx_mem_q[tx_rp_q];
    // TX load only peeks; the entry is consumed when its first bit is sampled.
    assign load_word = tx_empty ? '0 : tx_head;

    assign rx_push = word_done && !rx_full;
    assign rx_pop  = rx_valid && rx_ready;
    assign tx_push = tx_valid && !tx_full;
    assign tx_pop  = sample_e && first_bit && from_fifo_q;
    assign set_ovr = word_done && rx_full;
    assign set_udr = sample_e && first_bit && !from_fifo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            load_pend_q <= 1'b0;
            from_fifo_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ST_XFER;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        bit_cnt_q <= '0;
                        // cpha=0 must present the MSB before the first edge;
                        // cpha=1 defers the load to the first leading edge.
                        if (!cpha) begin
                            tx_shift_q  <= load_word;
                            from_fifo_q <= !tx_empty;
                            miso_q      <= load_word[DATA_WIDTH-1];
                        end else begin
                            load_pend_q <= 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (cs_rise) begin
                        state_q     <= ST_IDLE;
                        bit_cnt_q   <= '0;
                        load_pend_q <= 1'b0;
                        miso_q      <= 1'b0;
                    end else if (sample_e) begin
                        rx_shift_q <= rx_word;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q   <= '0;
                            load_pend_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end else if (shift_e) begin
                        if (load_pend_q) begin
                            tx_shift_q  <= load_word;
                            from_fifo_q <= !tx_empty;
                            miso_q      <= load_word[DATA_WIDTH-1];
                            load_pend_q <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                            miso_q     <= tx_shift_q[DATA_WIDTH-2];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A set event in the same cycle as clear_flags keeps the flag high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovr_q <= set_ovr | (ovr_q & ~clear_flags);
            udr_q <= set_udr | (udr_q & ~clear_flags);
        end
    end

    // ---------------- FIFOs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
                tx_mem_q[i] <= '0;
            end
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wp_q] <= rx_word;
                rx_wp_q           <= rx_wp_q + AW'(1);
            end
            if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
            rx_cnt_q <= rx_cnt_q + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);

            if (tx_push) begin
                tx_mem_q[tx_wp_q] <= tx_data;
                tx_wp_q           <= tx_wp_q + AW'(1);
            end
            if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
        end
    end

    assign spi_miso    = miso_q;
    assign rx_data     = rx_mem_q[rx_rp_q];
    assign rx_valid    = (rx_cnt_q != '0);
    assign tx_ready    = !tx_full;
    assign rx_overrun  = ovr_q;
    assign tx_underrun = udr_q;
    assign busy        = (state_q == ST_XFER);

endmodule

// File: tb/tb_spi_slave_stream.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_stream (8-bit words, 4-deep FIFOs).
// A behavioural SPI master drives the pins; expected values are hand-derived.
module tb_spi_slave_stream;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int HALF = 80;   // SCLK half period: 8 system clocks

    logic         clk = 1'b0;
    logic         rst;
    logic         spi_sclk, spi_mosi, spi_cs_n, spi_miso;
    logic         cpol, cpha;
    logic [W-1:0] rx_data, tx_data;
    logic         rx_valid, rx_ready, tx_valid, tx_ready;
    logic         rx_overrun, tx_underrun, clear_flags, busy;

    spi_slave_stream #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .cpol(cpol), .cpha(cpha),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .clear_flags(clear_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // master mode, kept separate from the DUT's cpol/cpha inputs
    logic mpol = 1'b0, mpha = 1'b0;

    logic         cap_en = 1'b0;
    logic [W-1:0] rxq[$];
    always @(negedge clk)
        if (cap_en && rx_valid && rx_ready) rxq.push_back(rx_data);

    task automatic set_mode(input logic p, input logic h);
        mpol = p; mpha = h; cpol = p; cpha = h;
    endtask

    task automatic push(input logic [W-1:0] d);
        @(negedge clk); tx_data = d; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_flags = 1'b1;
        @(negedge clk); clear_flags = 1'b0;
    endtask

    task automatic cs_begin();
        spi_sclk = mpol;
        #(4 * HALF);
        spi_cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_end();
        #(HALF);
        spi_cs_n = 1'b1;
        #(2 * HALF);
    endtask

    task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!mpha) begin
                spi_mosi = mo[W-1-i];
                #(HALF);
                mi = {mi[W-2:0], spi_miso};
                spi_sclk = ~spi_sclk;
                #(HALF);
                spi_sclk = ~spi_sclk;
            end else begin
                spi_sclk = ~spi_sclk;
                spi_mosi = mo[W-1-i];
                #(HALF);
                mi = {mi[W-2:0], spi_miso};
                spi_sclk = ~spi_sclk;
                #(HALF);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mi, mor;
        logic [W-1:0] bexp [3];
        bexp = '{8'h11, 8'h22, 8'h33};

        rst = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        cpol = 1'b0; cpha = 1'b0; rx_ready = 1'b0; tx_data = '0;
        tx_valid = 1'b0; clear_flags = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_miso", spi_miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_ovr", rx_overrun, 0);
        check("rst_udr", tx_underrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", busy, 0);

        // mode 0 single word: out 0xA5, in 0x3C
        push(8'hA5);
        set_mode(1'b0, 1'b0);
        cs_begin();
        check("cs_busy", busy, 1);
        xfer(8'h3C, 8, mi);
        check("m0_miso", mi, 8'hA5);
        cs_end();
        check("m0_busy_off", busy, 0);
        check("m0_rx_valid", rx_valid, 1);
        check("m0_rx_data", rx_data, 8'h3C);
        check("m0_ovr", rx_overrun, 0);
        check("m0_udr", tx_underrun, 0);
        pop();
        check("m0_rx_empty", rx_valid, 0);
        // TX FIFO must be empty: exactly four pushes fill it
        for (int i = 0; i < 3; i++) push(8'h5A);
        check("tx_ready_3", tx_ready, 1);
        push(8'h5A);
        check("tx_full_4", tx_ready, 0);

        // all four modes; DUT mode inputs are scrambled mid-transaction
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            cs_begin();
            cpol = ~mpol; cpha = ~mpha;
            xfer(8'hC3, 8, mi);
            cs_end();
            cpol = mpol; cpha = mpha;
            check($sformatf("mode%0d_miso", m), mi, 8'h5A);
            check($sformatf("mode%0d_rx_valid", m), rx_valid, 1);
            check($sformatf("mode%0d_rx_data", m), rx_data, 8'hC3);
            pop();
        end
        check("modes_rx_empty", rx_valid, 0);
        check("modes_ovr", rx_overrun, 0);
        check("modes_udr", tx_underrun, 0);

        // burst of three words in one window
        push(8'h11); push(8'h22); push(8'h33);
        set_mode(1'b0, 1'b0);
        rxq.delete();
        rx_ready = 1'b1; cap_en = 1'b1;
        cs_begin();
        for (int i = 0; i < 3; i++) begin
            xfer(bexp[i], 8, mi);
            check($sformatf("burst_miso%0d", i), mi, bexp[i]);
        end
        cs_end();
        cap_en = 1'b0; rx_ready = 1'b0;
        check("burst_rx_count", rxq.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < rxq.size()) check($sformatf("burst_rx%0d", i), rxq[i], bexp[i]);
        check("burst_ovr", rx_overrun, 0);
        check("burst_udr", tx_underrun, 0);

        // overrun and underrun: TX empty (burst popped exactly three), RX not drained
        cs_begin();
        xfer(8'h01, 8, mi);
        mor = mi;
        check("udr_first_word", tx_underrun, 1);
        check("ovr_first_word", rx_overrun, 0);
        for (int i = 2; i <= 4; i++) begin
            xfer(W'(i), 8, mi);
            mor = mor | mi;
        end
        check("ovr_after4", rx_overrun, 0);
        xfer(8'h05, 8, mi);
        mor = mor | mi;
        cs_end();
        check("ovr_after5", rx_overrun, 1);
        check("udr_miso_zero", mor, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_rx%0d", i), rx_data, i);
            pop();
        end
        check("ovr_rx_empty", rx_valid, 0);
        check("ovr_sticky", rx_overrun, 1);
        pulse_clear();
        check("clr_ovr", rx_overrun, 0);
        check("clr_udr", tx_underrun, 0);

        // abort after 5 bits, then a clean word
        cs_begin();
        xfer(8'hFF, 5, mi);
        cs_end();
        check("abort_no_push", rx_valid, 0);
        pulse_clear();
        // window with no SCLK edges must leave the queued word in place
        push(8'h77);
        cs_begin();
        cs_end();
        check("empty_win_udr", tx_underrun, 0);
        cs_begin();
        xfer(8'h81, 8, mi);
        cs_end();
        check("abort_next_miso", mi, 8'h77);
        check("abort_next_valid", rx_valid, 1);
        check("abort_next_rx", rx_data, 8'h81);
        check("abort_next_udr", tx_underrun, 0);

        // reset in the middle of a word (0x81 still queued in RX)
        cs_begin();
        xfer(8'hF0, 4, mi);
        check("mid_busy", busy, 1);
        check("mid_udr", tx_underrun, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_miso", spi_miso, 0);
        check("mrst_rx_data", rx_data, 0);
        check("mrst_rx_valid", rx_valid, 0);
        check("mrst_tx_ready", tx_ready, 1);
        check("mrst_ovr", rx_overrun, 0);
        check("mrst_udr", tx_underrun, 0);
        check("mrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("cs_low_at_release", busy, 0);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_rx_valid", rx_valid, 0);
        for (int i = 0; i < 3; i++) push(8'h00);
        check("post_rst_tx_3", tx_ready, 1);
        push(8'h00);
        check("post_rst_tx_4", tx_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
